// File: rtl/cal_kl_pipe.sv
// cal_kl_pipe: backward-extension k/l calculation stage of the SMEM pipeline.
// Two registered stages (S1 capture/precompute, S2 output) with valid/ready
// handshakes on both sides and credit-limited tracking of outstanding memory
// requests. Optional feature macro: CAL_KL_LINE_MERGE_EN adds the req_single
// output, flagging request tokens whose k and l fall in the same cache line.
module cal_kl_pipe #(
  parameter int CNT_W          = 64,
  parameter int ADDR_W         = 42,
  parameter int LINE_LSB       = 7,
  parameter int LINE_MSB       = 34,
  parameter int PAD_W          = 4,
  parameter int READ_NUM_WIDTH = 6,
  parameter int SB_W           = 256,
  parameter int MAX_OUT        = 16,
  localparam int OUT_W         = $clog2(MAX_OUT) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_status,
  input  logic                      in_finish,
  input  logic [READ_NUM_WIDTH-1:0] in_read_num,
  input  logic [CNT_W-1:0]          in_p_x0,
  input  logic [CNT_W-1:0]          in_p_x2,
  input  logic [CNT_W-1:0]          in_primary,
  input  logic [6:0]                in_mem_wr_addr,
  input  logic [SB_W-1:0]           in_sb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_status,
  output logic                      out_finish,
  output logic [READ_NUM_WIDTH-1:0] out_read_num,
  output logic [CNT_W-1:0]          out_k,
  output logic [CNT_W-1:0]          out_l,
  output logic [ADDR_W-1:0]         addr_k,
  output logic [ADDR_W-1:0]         addr_l,
  output logic                      req_valid,
  output logic [6:0]                out_mem_size,
  output logic [SB_W-1:0]           out_sb,
  input  logic                      credit_ret,
`ifdef CAL_KL_LINE_MERGE_EN
  output logic                      req_single,
`endif
  output logic [OUT_W-1:0]          outstanding
);

  localparam logic [5:0] ST_BUBBLE = 6'b00_0000;
  localparam logic [5:0] ST_INI    = 6'b00_1000;
  localparam logic [5:0] ST_RUN    = 6'b01_0000;
  localparam int         LINE_W    = LINE_MSB - LINE_LSB + 1;
  localparam int         FLD_W     = LINE_W + PAD_W;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TWO = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  // Cache-line address: line index bits with zero padding below, resized
  // (zero-extended or truncated) to the address width.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [LINE_W-1:0] line);
    logic [FLD_W-1:0] fld;
    fld = {line, {PAD_W{1'b0}}};
    return ADDR_W'(fld);
  endfunction

  // S1 registers
  logic                      r_s1_valid;
  logic                      r_s1_finish;
  logic                      r_s1_ini;
  logic [READ_NUM_WIDTH-1:0] r_s1_read_num;
  logic [CNT_W-1:0]          r_s1_kt;
  logic [CNT_W-1:0]          r_s1_lt;
  logic [CNT_W-1:0]          r_s1_km;
  logic [CNT_W-1:0]          r_s1_lm;
  logic [CNT_W-1:0]          r_s1_primary;
  logic [6:0]                r_s1_mem_wr_addr;
  logic [SB_W-1:0]           r_s1_sb;

  // S2 registers
  logic                      r_s2_valid;
  logic                      r_s2_finish;
  logic [5:0]                r_s2_status;
  logic                      r_s2_req;
  logic [READ_NUM_WIDTH-1:0] r_s2_read_num;
  logic [CNT_W-1:0]          r_s2_k;
  logic [CNT_W-1:0]          r_s2_l;
  logic [ADDR_W-1:0]         r_s2_addr_k;
  logic [ADDR_W-1:0]         r_s2_addr_l;
  logic [6:0]                r_s2_mem_size;
  logic [SB_W-1:0]           r_s2_sb;
  logic [OUT_W-1:0]          r_outstanding;

  // Combinational nets
  logic                      w_credit_ok;
  logic                      w_out_valid;
  logic                      w_out_fire;
  logic                      w_s2_adv;
  logic                      w_in_ready;
  logic                      w_in_keep;
  logic [CNT_W-1:0]          w_kt;
  logic [CNT_W-1:0]          w_km;
  logic [CNT_W-1:0]          w_sel_k;
  logic [CNT_W-1:0]          w_sel_l;
  logic [5:0]                w_nx_status;
  logic                      w_nx_req;
  logic [CNT_W-1:0]          w_nx_k;
  logic [CNT_W-1:0]          w_nx_l;
  logic [ADDR_W-1:0]         w_nx_addr_k;
  logic [ADDR_W-1:0]         w_nx_addr_l;
  logic [6:0]                w_nx_mem_size;
  logic [SB_W-1:0]           w_nx_sb;
  logic                      w_inc;
  logic                      w_dec;
  logic [OUT_W-1:0]          w_nx_outstanding;

  // A returning credit frees a slot in the same cycle, so a held request may
  // transfer together with credit_ret. Finish tokens never need credit.
  assign w_credit_ok = (r_outstanding != OUT_MAX) || credit_ret;
  assign w_out_valid = r_s2_valid && (!r_s2_req || w_credit_ok);
  assign w_out_fire  = w_out_valid && out_ready;
  assign w_s2_adv    = !r_s2_valid || w_out_fire;
  assign w_in_ready  = !r_s1_valid || w_s2_adv;
  assign w_in_keep   = in_finish || (in_status == ST_INI) || (in_status == ST_RUN);
  assign w_kt        = in_p_x0 - ONE;
  assign w_km        = in_p_x0 - TWO;

  // S1 capture: precompute both candidate k/l pairs; unknown-status tokens are
  // accepted but not marked valid, so they vanish here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid       <= 1'b0;
      r_s1_finish      <= 1'b0;
      r_s1_ini         <= 1'b0;
      r_s1_read_num    <= {READ_NUM_WIDTH{1'b0}};
      r_s1_kt          <= {CNT_W{1'b0}};
      r_s1_lt          <= {CNT_W{1'b0}};
      r_s1_km          <= {CNT_W{1'b0}};
      r_s1_lm          <= {CNT_W{1'b0}};
      r_s1_primary     <= {CNT_W{1'b0}};
      r_s1_mem_wr_addr <= 7'd0;
      r_s1_sb          <= {SB_W{1'b0}};
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid && w_in_keep;
      if (in_valid) begin
        r_s1_finish      <= in_finish;
        r_s1_ini         <= (in_status == ST_INI);
        r_s1_read_num    <= in_read_num;
        r_s1_kt          <= w_kt;
        r_s1_lt          <= w_kt + in_p_x2;
        r_s1_km          <= w_km;
        r_s1_lm          <= w_km + in_p_x2;
        r_s1_primary     <= in_primary;
        r_s1_mem_wr_addr <= in_mem_wr_addr;
        r_s1_sb          <= in_sb;
      end
    end
  end

  // Primary correction, address formation and token-class output shaping.
  always_comb begin
    w_sel_k       = (r_s1_kt >= r_s1_primary) ? r_s1_km : r_s1_kt;
    w_sel_l       = (r_s1_lt >= r_s1_primary) ? r_s1_lm : r_s1_lt;
    w_nx_status   = ST_RUN;
    w_nx_req      = 1'b1;
    w_nx_k        = w_sel_k;
    w_nx_l        = w_sel_l;
    w_nx_addr_k   = line_addr(w_sel_k[LINE_MSB:LINE_LSB]);
    w_nx_addr_l   = line_addr(w_sel_l[LINE_MSB:LINE_LSB]);
    w_nx_mem_size = r_s1_mem_wr_addr;
    w_nx_sb       = r_s1_sb;
    if (r_s1_finish) begin
      w_nx_status = ST_BUBBLE;
      w_nx_req    = 1'b0;
      w_nx_k      = {CNT_W{1'b0}};
      w_nx_l      = {CNT_W{1'b0}};
      w_nx_addr_k = {ADDR_W{1'b0}};
      w_nx_addr_l = {ADDR_W{1'b0}};
      w_nx_sb     = {SB_W{1'b0}};
    end else if (r_s1_ini) begin
      w_nx_mem_size = 7'd0;
    end else begin
      w_nx_mem_size = r_s1_mem_wr_addr;
    end
  end

  // S2 output register: loads from S1 whenever the current result has left
  // (or was never there); otherwise every output holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_finish   <= 1'b0;
      r_s2_status   <= ST_BUBBLE;
      r_s2_req      <= 1'b0;
      r_s2_read_num <= {READ_NUM_WIDTH{1'b0}};
      r_s2_k        <= {CNT_W{1'b0}};
      r_s2_l        <= {CNT_W{1'b0}};
      r_s2_addr_k   <= {ADDR_W{1'b0}};
      r_s2_addr_l   <= {ADDR_W{1'b0}};
      r_s2_mem_size <= 7'd0;
      r_s2_sb       <= {SB_W{1'b0}};
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_finish   <= r_s1_finish;
        r_s2_status   <= w_nx_status;
        r_s2_req      <= w_nx_req;
        r_s2_read_num <= r_s1_read_num;
        r_s2_k        <= w_nx_k;
        r_s2_l        <= w_nx_l;
        r_s2_addr_k   <= w_nx_addr_k;
        r_s2_addr_l   <= w_nx_addr_l;
        r_s2_mem_size <= w_nx_mem_size;
        r_s2_sb       <= w_nx_sb;
      end
    end
  end

  // Outstanding-count update: +1 per transferred request, -1 per credit,
  // simultaneous events cancel, credit at zero is ignored.
  always_comb begin
    w_inc            = w_out_fire && r_s2_req;
    w_dec            = credit_ret && (r_outstanding != {OUT_W{1'b0}});
    w_nx_outstanding = r_outstanding;
    case ({w_inc, w_dec})
      2'b10:   w_nx_outstanding = r_outstanding + OUT_ONE;
      2'b01:   w_nx_outstanding = r_outstanding - OUT_ONE;
      default: w_nx_outstanding = r_outstanding;
    endcase
  end

  // Outstanding request counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= {OUT_W{1'b0}};
    end else begin
      r_outstanding <= w_nx_outstanding;
    end
  end

`ifdef CAL_KL_LINE_MERGE_EN
  logic r_s2_single;

  // Same-line flag: one memory read serves both k and l.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_single <= 1'b0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_s2_single <= w_nx_req && (w_nx_addr_k == w_nx_addr_l);
    end
  end

  assign req_single = r_s2_single;
`endif

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_status   = r_s2_status;
  assign out_finish   = r_s2_finish;
  assign out_read_num = r_s2_read_num;
  assign out_k        = r_s2_k;
  assign out_l        = r_s2_l;
  assign addr_k       = r_s2_addr_k;
  assign addr_l       = r_s2_addr_l;
  assign req_valid    = r_s2_req;
  assign out_mem_size = r_s2_mem_size;
  assign out_sb       = r_s2_sb;
  assign outstanding  = r_outstanding;

endmodule

// File: tb/tb_cal_kl_pipe.sv
// Directed self-checking bench for cal_kl_pipe (MAX_OUT reduced to 2).
`timescale 1ns/1ps
module tb_cal_kl_pipe;
  localparam logic [5:0] ST_INI = 6'b00_1000;
  localparam logic [5:0] ST_RUN = 6'b01_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_finish, out_valid, out_ready, out_finish;
  logic [5:0]   in_status, out_status, in_read_num, out_read_num;
  logic [63:0]  in_p_x0, in_p_x2, in_primary, out_k, out_l;
  logic [6:0]   in_mem_wr_addr, out_mem_size;
  logic [255:0] in_sb, out_sb;
  logic [41:0]  addr_k, addr_l;
  logic         req_valid, credit_ret;
  logic [1:0]   outstanding;

  int checks = 0;
  int failures = 0;

  cal_kl_pipe #(.MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_status(in_status), .in_finish(in_finish), .in_read_num(in_read_num),
    .in_p_x0(in_p_x0), .in_p_x2(in_p_x2), .in_primary(in_primary),
    .in_mem_wr_addr(in_mem_wr_addr), .in_sb(in_sb), .out_valid(out_valid),
    .out_ready(out_ready), .out_status(out_status), .out_finish(out_finish),
    .out_read_num(out_read_num), .out_k(out_k), .out_l(out_l), .addr_k(addr_k),
    .addr_l(addr_l), .req_valid(req_valid), .out_mem_size(out_mem_size),
    .out_sb(out_sb), .credit_ret(credit_ret), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [5:0] st, input logic fin, input logic [63:0] x0,
                       input logic [63:0] x2, input logic [63:0] prim,
                       input logic [5:0] rn, input logic [6:0] mwa, input logic [255:0] sb);
    in_valid = 1'b1; in_status = st; in_finish = fin; in_p_x0 = x0; in_p_x2 = x2;
    in_primary = prim; in_read_num = rn; in_mem_wr_addr = mwa; in_sb = sb;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_status = 6'd0; in_finish = 1'b0; in_p_x0 = 64'd0; in_p_x2 = 64'd0;
    in_primary = 64'd0; in_read_num = 6'd0; in_mem_wr_addr = 7'd0; in_sb = 256'd0;
  endtask

  // Presents one token for one cycle into an empty pipe, then waits (bounded)
  // for out_valid; returns at negedge+1 with the result visible.
  task automatic send_wait(input logic [5:0] st, input logic fin, input logic [63:0] x0,
                           input logic [63:0] x2, input logic [63:0] prim,
                           input logic [5:0] rn, input logic [6:0] mwa, input logic [255:0] sb,
                           output bit found, output int lat);
    @(negedge clk); drive(st, fin, x0, x2, prim, rn, mwa, sb);
    @(negedge clk); idle();
    found = 1'b0; lat = -1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) begin found = 1'b1; lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    @(negedge clk); credit_ret = 1'b1;
    repeat (3) @(negedge clk);
    credit_ret = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (outstanding !== 2'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (out_status !== 6'd0 || out_k !== 64'd0 || addr_k !== 42'd0 || req_valid !== 1'b0)
      begin failures++; $display("FAIL reset_outputs status=%h k=%h addr_k=%h req=%b exp=all zero", out_status, out_k, addr_k, req_valid); end
  endtask

  task automatic test_basic_ini();
    bit found; int lat;
    logic [255:0] sb;
    sb = {64'hDEAD_BEEF_0000_0001, 64'h1234, 64'h5678, 64'h9ABC};
    out_ready = 1'b1; credit_ret = 1'b0;
    send_wait(ST_INI, 1'b0, 64'h100, 64'h10, 64'h1000, 6'd3, 7'h55, sb, found, lat);
    checks++; if (!found || lat !== 1) begin failures++; $display("FAIL basic_latency found=%b lat=%0d exp lat=1", found, lat); end
    checks++; if (out_k !== 64'hFF) begin failures++; $display("FAIL basic_k got=%h exp=ff", out_k); end
    checks++; if (out_l !== 64'h10F) begin failures++; $display("FAIL basic_l got=%h exp=10f", out_l); end
    checks++; if (addr_k !== 42'h10) begin failures++; $display("FAIL basic_addr_k got=%h exp=10", addr_k); end
    checks++; if (addr_l !== 42'h20) begin failures++; $display("FAIL basic_addr_l got=%h exp=20", addr_l); end
    checks++; if (out_status !== ST_RUN || req_valid !== 1'b1 || out_finish !== 1'b0)
      begin failures++; $display("FAIL basic_class status=%h req=%b fin=%b exp=10/1/0", out_status, req_valid, out_finish); end
    checks++; if (out_mem_size !== 7'd0) begin failures++; $display("FAIL basic_mem_size got=%h exp=0", out_mem_size); end
    checks++; if (out_read_num !== 6'd3 || out_sb !== sb)
      begin failures++; $display("FAIL basic_passthru rn=%0d sb=%h exp rn=3 sb=%h", out_read_num, out_sb, sb); end
    @(negedge clk); #1;
    checks++; if (outstanding !== 2'd1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL basic_after_xfer outstanding=%0d valid=%b exp=1/0", outstanding, out_valid); end
    credit_ret = 1'b1;
    @(negedge clk); credit_ret = 1'b0; #1;
    checks++; if (outstanding !== 2'd0) begin failures++; $display("FAIL basic_credit outstanding=%0d exp=0", outstanding); end
  endtask

  task automatic test_primary_correction();
    logic [63:0] vx0 [4] = '{64'h100, 64'h1000, 64'h0, 64'h81};
    logic [63:0] vx2 [4] = '{64'h10, 64'h200, 64'h5, 64'h0};
    logic [63:0] vpr [4] = '{64'h105, 64'h800, 64'h0, 64'h80};
    logic [63:0] ek  [4] = '{64'hFF, 64'hFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7F};
    logic [63:0] el  [4] = '{64'h10E, 64'h11FE, 64'h3, 64'h7F};
    logic [41:0] eak [4] = '{42'h10, 42'h1F0, 42'h0_FFFF_FFF0, 42'h0};
    logic [41:0] eal [4] = '{42'h20, 42'h230, 42'h0, 42'h0};
    bit found; int lat;
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_wait(ST_RUN, 1'b0, vx0[v], vx2[v], vpr[v], 6'(v + 20), 7'(v + 33), 256'd0, found, lat);
      checks++; if (!found) begin failures++; $display("FAIL sel%0d_timeout out_valid never rose", v); end
      checks++; if (out_k !== ek[v] || out_l !== el[v])
        begin failures++; $display("FAIL sel%0d_kl got k=%h l=%h exp k=%h l=%h", v, out_k, out_l, ek[v], el[v]); end
      checks++; if (addr_k !== eak[v] || addr_l !== eal[v])
        begin failures++; $display("FAIL sel%0d_addr got %h/%h exp %h/%h", v, addr_k, addr_l, eak[v], eal[v]); end
      checks++; if (out_mem_size !== 7'(v + 33) || out_status !== ST_RUN)
        begin failures++; $display("FAIL sel%0d_run mem=%h status=%h exp mem=%h status=10", v, out_mem_size, out_status, 7'(v + 33)); end
      drain();
    end
  endtask

  task automatic test_finish();
    bit found; int lat;
    out_ready = 1'b1; credit_ret = 1'b0;
    send_wait(ST_RUN, 1'b0, 64'h300, 64'h1, 64'hFFFF, 6'd1, 7'd2, 256'd1, found, lat);
    @(negedge clk);
    send_wait(ST_INI, 1'b1, 64'h5555, 64'h1, 64'h10, 6'd5, 7'd9, {4{64'hA5A5}}, found, lat);
    checks++; if (!found) begin failures++; $display("FAIL finish_timeout out_valid never rose"); end
    checks++; if (out_finish !== 1'b1 || out_status !== 6'd0 || req_valid !== 1'b0)
      begin failures++; $display("FAIL finish_class fin=%b status=%h req=%b exp=1/00/0", out_finish, out_status, req_valid); end
    checks++; if (out_mem_size !== 7'd9 || out_read_num !== 6'd5)
      begin failures++; $display("FAIL finish_fields mem=%0d rn=%0d exp=9/5", out_mem_size, out_read_num); end
    checks++; if (out_k !== 64'd0 || out_l !== 64'd0 || addr_k !== 42'd0 || addr_l !== 42'd0 || out_sb !== 256'd0)
      begin failures++; $display("FAIL finish_zeroed k=%h l=%h ak=%h al=%h sb=%h exp all 0", out_k, out_l, addr_k, addr_l, out_sb); end
    @(negedge clk); #1;
    checks++; if (outstanding !== 2'd1) begin failures++; $display("FAIL finish_outstanding got=%0d exp=1", outstanding); end
    drain();
  endtask

  task automatic test_drop();
    bit found; int lat;
    out_ready = 1'b1;
    send_wait(6'b00_0001, 1'b0, 64'h400, 64'h1, 64'hFFFF, 6'd11, 7'd3, 256'd0, found, lat);
    checks++; if (found) begin failures++; $display("FAIL drop_unknown_status got out_valid=1 exp=0"); end
    send_wait(ST_RUN, 1'b0, 64'h400, 64'h1, 64'hFFFF, 6'd12, 7'd3, 256'd0, found, lat);
    checks++; if (!found || out_read_num !== 6'd12)
      begin failures++; $display("FAIL drop_next found=%b rn=%0d exp=1/12", found, out_read_num); end
    drain();
  endtask

  task automatic test_back_to_back();
    int sent, rcvd;
    bit held, saw_stall;
    logic [63:0] held_k, ek;
    logic [5:0]  held_rn;
    sent = 0; rcvd = 0; held = 1'b0; saw_stall = 1'b0; held_k = 64'd0; held_rn = 6'd0;
    credit_ret = 1'b1;
    for (int cyc = 0; cyc < 60 && rcvd < 5; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      if (sent < 5) drive(ST_RUN, 1'b0, 64'h1000 * 64'(sent + 1), 64'h80, 64'hFFFF_FFFF_FFFF_FFFF,
                          6'(sent + 1), 7'(sent + 10), {4{64'(sent)}});
      else idle();
      #1;
      if (held) begin
        checks++; if (out_valid !== 1'b1 || out_k !== held_k || out_read_num !== held_rn)
          begin failures++; $display("FAIL bp_hold valid=%b k=%h rn=%0d exp 1/%h/%0d", out_valid, out_k, out_read_num, held_k, held_rn); end
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        ek = 64'h1000 * 64'(rcvd + 1) - 64'd1;
        checks++; if (out_read_num !== 6'(rcvd + 1) || out_k !== ek || out_l !== ek + 64'h80 || out_mem_size !== 7'(rcvd + 10))
          begin failures++; $display("FAIL bp_token%0d rn=%0d k=%h l=%h mem=%0d exp rn=%0d k=%h", rcvd, out_read_num, out_k, out_l, out_mem_size, rcvd + 1, ek); end
        rcvd++;
      end else if (out_valid) begin
        held = 1'b1; held_k = out_k; held_rn = out_read_num;
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) sent++;
    end
    idle(); out_ready = 1'b1;
    checks++; if (rcvd !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", rcvd); end
    checks++; if (!saw_stall) begin failures++; $display("FAIL bp_in_ready never fell exp a stall"); end
    repeat (4) @(negedge clk);
    credit_ret = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || outstanding !== 2'd0)
      begin failures++; $display("FAIL bp_tail valid=%b outstanding=%0d exp=0/0", out_valid, outstanding); end
  endtask

  task automatic test_credit();
    bit found; int lat;
    out_ready = 1'b1; credit_ret = 1'b0;
    @(negedge clk); drive(ST_RUN, 1'b0, 64'h200, 64'h1, 64'hFFFF, 6'd1, 7'd1, 256'd0);
    @(negedge clk); drive(ST_RUN, 1'b0, 64'h300, 64'h1, 64'hFFFF, 6'd2, 7'd1, 256'd0);
    @(negedge clk); drive(ST_RUN, 1'b0, 64'h400, 64'h1, 64'hFFFF, 6'd3, 7'd1, 256'd0); #1;
    checks++; if (out_valid !== 1'b1 || out_read_num !== 6'd1)
      begin failures++; $display("FAIL credit_first valid=%b rn=%0d exp=1/1", out_valid, out_read_num); end
    @(negedge clk); idle(); #1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || outstanding !== 2'd2)
      begin failures++; $display("FAIL credit_block valid=%b outstanding=%0d exp=0/2", out_valid, outstanding); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_k !== 64'h3FF || out_read_num !== 6'd3)
      begin failures++; $display("FAIL credit_held valid=%b k=%h rn=%0d exp=0/3ff/3", out_valid, out_k, out_read_num); end
    @(negedge clk); credit_ret = 1'b1; #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL credit_release valid=%b exp=1", out_valid); end
    @(negedge clk); credit_ret = 1'b0; #1;
    checks++; if (outstanding !== 2'd2 || out_valid !== 1'b0)
      begin failures++; $display("FAIL credit_coincident outstanding=%0d valid=%b exp=2/0", outstanding, out_valid); end
    send_wait(ST_RUN, 1'b1, 64'h0, 64'h0, 64'h0, 6'd4, 7'd6, 256'd0, found, lat);
    checks++; if (!found || out_finish !== 1'b1 || outstanding !== 2'd2)
      begin failures++; $display("FAIL credit_finish_bypass found=%b fin=%b outstanding=%0d exp=1/1/2", found, out_finish, outstanding); end
    @(negedge clk); #1;
    checks++; if (outstanding !== 2'd2) begin failures++; $display("FAIL credit_finish_count got=%0d exp=2", outstanding); end
    drain(); #1;
    checks++; if (outstanding !== 2'd0) begin failures++; $display("FAIL credit_underflow got=%0d exp=0", outstanding); end
  endtask

  task automatic test_async_reset();
    bit found; int lat; int seen;
    out_ready = 1'b1; credit_ret = 1'b0;
    send_wait(ST_RUN, 1'b0, 64'h500, 64'h1, 64'hFFFF, 6'd7, 7'd1, 256'd0, found, lat);
    @(negedge clk); out_ready = 1'b0;
    drive(ST_RUN, 1'b0, 64'h600, 64'h1, 64'hFFFF, 6'd8, 7'd1, 256'd0);
    @(negedge clk); drive(ST_RUN, 1'b0, 64'h700, 64'h1, 64'hFFFF, 6'd9, 7'd1, 256'd0);
    @(negedge clk); idle(); #1;
    checks++; if (out_valid !== 1'b1 || outstanding !== 2'd1 || in_ready !== 1'b0)
      begin failures++; $display("FAIL arst_pre valid=%b outstanding=%0d in_ready=%b exp=1/1/0", out_valid, outstanding, in_ready); end
    #1 rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || outstanding !== 2'd0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL arst_immediate valid=%b outstanding=%0d in_ready=%b exp=0/0/1", out_valid, outstanding, in_ready); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0 || outstanding !== 2'd0)
      begin failures++; $display("FAIL arst_stale seen=%0d outstanding=%0d exp=0/0", seen, outstanding); end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; credit_ret = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_basic_ini();
    test_primary_correction();
    test_finish();
    test_drop();
    test_back_to_back();
    test_credit();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
